// File: rtl/segment_7.sv
`default_nettype none
// ============================================================================
// Module   : segment_7
// Purpose  : Registered 3-bit binary to seven-segment decoder with lamp-test
//            and blanking, polarity selectable for common anode/cathode.
// Revision : 1.0 - initial release
// ============================================================================
module segment_7 #(
  parameter bit ACTIVE_LOW = 1'b0
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [2:0] binary,
  input  logic       blank,
  input  logic       lamp_test,
  output logic [0:6] segmentcode,
  output logic       valid
);

  // Polarity mask; XOR-ing the logical pattern gives the pin drive.
  localparam logic [0:6] c_pol_mask = ACTIVE_LOW ? 7'b1111111 : 7'b0000000;
  localparam logic [0:6] c_all_on   = 7'b1111111;
  localparam logic [0:6] c_all_off  = 7'b0000000;

  logic [0:6] w_decoded;
  logic [0:6] w_logical;
  logic [0:6] r_segmentcode;
  logic       r_valid;

  always_comb begin
    w_decoded = c_all_off;
    case (binary)
      3'd0: w_decoded = 7'b1111110;
      3'd1: w_decoded = 7'b0110000;
      3'd2: w_decoded = 7'b1101101;
      3'd3: w_decoded = 7'b1111001;
      3'd4: w_decoded = 7'b0110011;
      3'd5: w_decoded = 7'b1011011;
      3'd6: w_decoded = 7'b1011111;
      3'd7: w_decoded = 7'b1110000;
      default: w_decoded = c_all_off;
    endcase
  end

  always_comb begin
    w_logical = w_decoded;
    if (lamp_test) begin
      w_logical = c_all_on;
    end else if (blank) begin
      w_logical = c_all_off;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_segmentcode <= c_all_off ^ c_pol_mask;
      r_valid       <= 1'b0;
    end else begin
      r_segmentcode <= w_logical ^ c_pol_mask;
      r_valid       <= 1'b1;
    end
  end

  assign segmentcode = r_segmentcode;
  assign valid       = r_valid;

endmodule
`default_nettype wire

// File: tb/tb_segment_7.sv
`default_nettype none
// ============================================================================
// Module   : tb_segment_7
// Purpose  : Self-checking bench for segment_7 (both polarities) against a
//            per-segment digit-set reference model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_segment_7;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [2:0] binary = 3'd0;
  logic       blank = 1'b0;
  logic       lamp_test = 1'b0;
  logic [0:6] seg_ah;
  logic [0:6] seg_al;
  logic       valid_ah;
  logic       valid_al;

  int passes = 0;
  int total  = 0;

  // For each segment a..g, the set of digits (bit n = digit n) that light it.
  logic [7:0] seg_digits [7] = '{8'b11101101, 8'b10011111, 8'b11111011,
                                 8'b01101101, 8'b01000101, 8'b01110001,
                                 8'b01111100};

  logic [0:6] exp_ah = 7'b0000000;
  logic [0:6] exp_al = 7'b1111111;
  logic       exp_valid = 1'b0;

  always #5 clk = ~clk;

  segment_7 #(.ACTIVE_LOW(1'b0)) u_dut_ah (
    .clk(clk), .rst(rst), .binary(binary), .blank(blank),
    .lamp_test(lamp_test), .segmentcode(seg_ah), .valid(valid_ah)
  );

  segment_7 #(.ACTIVE_LOW(1'b1)) u_dut_al (
    .clk(clk), .rst(rst), .binary(binary), .blank(blank),
    .lamp_test(lamp_test), .segmentcode(seg_al), .valid(valid_al)
  );

  function automatic logic [0:6] model(input logic r, input logic [2:0] b,
                                       input logic bl, input logic lt,
                                       input logic inv);
    logic [0:6] p;
    p = 7'b0000000;
    if (!r && lt) begin
      p = 7'b1111111;
    end else if (!r && !bl) begin
      for (int s = 0; s < 7; s++) p[s] = seg_digits[s][b];
    end
    return inv ? ~p : p;
  endfunction

  task automatic check7(input string tag, input logic [0:6] obs, input logic [0:6] expv);
    total++;
    assert (obs === expv) passes++;
    else $error("FAIL %s observed=%b expected=%b", tag, obs, expv);
  endtask

  task automatic check1(input string tag, input logic obs, input logic expv);
    total++;
    assert (obs === expv) passes++;
    else $error("FAIL %s observed=%b expected=%b", tag, obs, expv);
  endtask

  // Drive inputs mid-cycle, confirm outputs hold, then check after the edge.
  task automatic step(input logic r, input logic [2:0] b, input logic bl, input logic lt);
    @(negedge clk);
    rst = r; binary = b; blank = bl; lamp_test = lt;
    #1;
    check7("hold_ah", seg_ah, exp_ah);
    check7("hold_al", seg_al, exp_al);
    exp_ah    = model(r, b, bl, lt, 1'b0);
    exp_al    = model(r, b, bl, lt, 1'b1);
    exp_valid = !r;
    @(posedge clk);
    #1;
    check7("seg_ah", seg_ah, exp_ah);
    check7("seg_al", seg_al, exp_al);
    check1("valid_ah", valid_ah, exp_valid);
    check1("valid_al", valid_al, exp_valid);
  endtask

  initial begin
    // Reset with a live digit on the input, then release.
    @(posedge clk);
    #1;
    step(1'b1, 3'd5, 1'b0, 1'b0);
    step(1'b1, 3'd5, 1'b0, 1'b0);
    check7("reset_ah_literal", seg_ah, 7'b0000000);
    check7("reset_al_literal", seg_al, 7'b1111111);
    step(1'b0, 3'd5, 1'b0, 1'b0);
    check7("first_decode_literal", seg_ah, 7'b1011011);

    // Sweep with each value held for 10 cycles.
    foreach (seg_digits[k]) begin end
    for (int i = 0; i < 5; i++) begin
      logic [2:0] v;
      v = (i == 4) ? 3'd5 : 3'(i);
      for (int c = 0; c < 10; c++) step(1'b0, v, 1'b0, 1'b0);
    end

    // Remaining codes, then back-to-back single-cycle changes.
    step(1'b0, 3'd4, 1'b0, 1'b0);
    step(1'b0, 3'd6, 1'b0, 1'b0);
    step(1'b0, 3'd7, 1'b0, 1'b0);
    check7("digit7_literal", seg_ah, 7'b1110000);
    for (int i = 0; i < 8; i++) step(1'b0, 3'(7 - i), 1'b0, 1'b0);

    // Blank, lamp-test over blank, then release both.
    step(1'b0, 3'd2, 1'b1, 1'b0);
    step(1'b0, 3'd2, 1'b1, 1'b1);
    check7("lamp_al_literal", seg_al, 7'b0000000);
    step(1'b0, 3'd2, 1'b0, 1'b0);
    check7("release_literal", seg_ah, 7'b1101101);

    // Reset in mid-stream.
    step(1'b0, 3'd3, 1'b0, 1'b0);
    step(1'b1, 3'd3, 1'b0, 1'b1);
    step(1'b0, 3'd3, 1'b0, 1'b0);

    // Active-low spot values.
    step(1'b0, 3'd0, 1'b0, 1'b0);
    check7("al_zero_literal", seg_al, 7'b0000001);
    step(1'b0, 3'd1, 1'b0, 1'b0);
    check7("al_one_literal", seg_al, 7'b1001111);

    // Randomized traffic.
    for (int i = 0; i < 300; i++) begin
      step(($urandom_range(0, 15) == 0), 3'($urandom_range(0, 7)),
           ($urandom_range(0, 3) == 0), ($urandom_range(0, 5) == 0));
    end

    $display("%0d/%0d checks passed", passes, total);
    $finish;
  end

endmodule
`default_nettype wire
